// File: rtl/tdm_mux_scanner_pkg.sv
// Shared constants and FSM state type for the TDM scanner and the
// demultiplexer that consumes its sel/data pair.
package tdm_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } scanState_t;

endpackage

// File: rtl/tdm_mux_scanner_if.sv
// Channel-side inputs and demultiplexer-side outputs of the scanner.
// valid qualifies sel and data in the same cycle; there is no ready because
// the demultiplexer consumes every cycle, and data is 0 whenever valid is 0.
interface tdm_mux_scanner_if;
  import tdm_pkg::*;

  logic              en;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] ch_data;
  logic              data;
  logic [SEL_W-1:0]  sel;
  logic              valid;
  logic              slot_done;

  modport master (
    input  en, req, ch_data,
    output data, sel, valid, slot_done
  );

  modport slave (
    output en, req, ch_data,
    input  data, sel, valid, slot_done
  );
endinterface

// File: rtl/tdm_mux_scanner_rr_arbiter_4.sv
// Combinational rotating-priority picker: searches from last+1 upward
// (mod 4) and returns the first requesting channel.
module rr_arbiter_4
  import tdm_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  last,
  output logic [SEL_W-1:0]  gnt_idx,
  output logic              any
);

  logic [SEL_W-1:0] candidate;
  logic             found;

  always_comb begin
    gnt_idx   = last;
    found     = 1'b0;
    candidate = '0;
    // The 2-bit add wraps naturally, giving the mod-4 rotation.
    for (int k = 1; k <= NUM_CH; k++) begin
      candidate = last + SEL_W'(k);
      if (!found && req[candidate]) begin
        gnt_idx = candidate;
        found   = 1'b1;
      end
    end
    any = found;
  end

endmodule

// File: rtl/tdm_mux_scanner.sv
// Time-division scanner: grants four channels round-robin, holds each grant
// for DWELL cycles and forwards the granted channel's bit on data with sel.
module tdm_mux_scanner
  import tdm_pkg::*;
#(
  parameter  int DWELL = 4,
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1
) (
  input  logic       clk,
  input  logic       rst_n,
  tdm_mux_scanner_if.master bus,
  output scanState_t dbgState
);

  scanState_t       state, stateNext;
  logic [SEL_W-1:0] selQ, selNext;
  logic [SEL_W-1:0] lastQ, lastNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic             dataQ, dataNext;
  logic [SEL_W-1:0] gntIdx;
  logic             anyReq;
  logic             slotEnd;

  rr_arbiter_4 u_arb (
    .req     (bus.req),
    .last    (lastQ),
    .gnt_idx (gntIdx),
    .any     (anyReq)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      selQ  <= '0;
      lastQ <= SEL_W'(NUM_CH - 1);
      cnt   <= '0;
      dataQ <= 1'b0;
    end else begin
      state <= stateNext;
      selQ  <= selNext;
      lastQ <= lastNext;
      cnt   <= cntNext;
      dataQ <= dataNext;
    end
  end

  // A slot ends on full dwell or when its own channel withdraws the request.
  assign slotEnd = (state == GRANT) && ((cnt == '0) || !bus.req[selQ]);

  always_comb begin
    stateNext = state;
    selNext   = selQ;
    lastNext  = lastQ;
    cntNext   = cnt;
    dataNext  = 1'b0;

    if ((state == IDLE) || slotEnd) begin
      if (bus.en && anyReq) begin
        stateNext = GRANT;
        selNext   = gntIdx;
        lastNext  = gntIdx;
        cntNext   = CNT_W'(DWELL - 1);
        dataNext  = bus.ch_data[gntIdx];
      end else begin
        stateNext = IDLE;
      end
    end else begin
      cntNext  = cnt - CNT_W'(1);
      dataNext = bus.ch_data[selQ];
    end
  end

  assign bus.sel       = selQ;
  assign bus.data      = dataQ;
  assign bus.valid     = (state == GRANT);
  assign bus.slot_done = (state == GRANT) && (cnt == '0);
  assign dbgState      = state;

endmodule

// File: tb/tb_tdm_mux_scanner.sv
// Self-checking bench for tdm_mux_scanner: a DWELL=4 and a DWELL=1 instance
// share stimulus and are compared each cycle against a slot-level model.
module tb_tdm_mux_scanner;
  import tdm_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  scanState_t dbg0, dbg1;

  tdm_mux_scanner_if bus0 ();
  tdm_mux_scanner_if bus1 ();

  tdm_mux_scanner #(.DWELL(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0), .dbgState(dbg0));
  tdm_mux_scanner #(.DWELL(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1), .dbgState(dbg1));

  always #5 clk = ~clk;

  int nChecks = 0;
  int nErrors = 0;

  // Expected {sel, valid, data, slot_done}: instance 0 then instance 1 per cycle.
  logic [4:0] expQ[$];

  // Slot-level reference: active flag, channel, cycles left in slot, pointer.
  logic       mActive[2];
  logic [1:0] mSel[2];
  int         mRem[2];
  logic [1:0] mLast[2];
  logic       mData[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    for (int u = 0; u < 2; u++) begin
      mActive[u] = 1'b0;
      mSel[u]    = 2'd0;
      mRem[u]    = 0;
      mLast[u]   = 2'd3;
      mData[u]   = 1'b0;
    end
  endtask

  task automatic modelStep(input int u, input int dwell);
    logic ending, start;
    int pick, c;
    ending = mActive[u] && ((mRem[u] == 1) || !bus0.req[mSel[u]]);
    start  = (!mActive[u] || ending) && bus0.en && (bus0.req != 4'b0000);
    pick   = -1;
    for (int i = 1; i <= 4; i++) begin
      c = (int'(mLast[u]) + i) % 4;
      if (pick < 0 && bus0.req[c]) pick = c;
    end
    if (start) begin
      mActive[u] = 1'b1;
      mSel[u]    = 2'(pick);
      mLast[u]   = 2'(pick);
      mRem[u]    = dwell;
      mData[u]   = bus0.ch_data[pick];
    end else if (mActive[u] && !ending) begin
      mRem[u]  = mRem[u] - 1;
      mData[u] = bus0.ch_data[mSel[u]];
    end else begin
      mActive[u] = 1'b0;
      mData[u]   = 1'b0;
    end
    expQ.push_back({mSel[u], mActive[u], mData[u], (mActive[u] && mRem[u] == 1)});
  endtask

  task automatic drive(input logic e, input logic [3:0] r, input logic [3:0] d);
    bus0.en = e;  bus0.req = r;  bus0.ch_data = d;
    bus1.en = e;  bus1.req = r;  bus1.ch_data = d;
  endtask

  task automatic tick(input string tag);
    logic [4:0] e0, e1;
    @(posedge clk);
    modelStep(0, 4);
    modelStep(1, 1);
    #1;
    e0 = expQ.pop_front();
    e1 = expQ.pop_front();
    check({tag, "/dwell4"}, 32'({bus0.sel, bus0.valid, bus0.data, bus0.slot_done}), 32'(e0));
    check({tag, "/dwell1"}, 32'({bus1.sel, bus1.valid, bus1.data, bus1.slot_done}), 32'(e1));
  endtask

  initial begin
    drive(1'b0, 4'b0000, 4'b0000);
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("resetOut", 32'({bus0.sel, bus0.valid, bus0.data, bus0.slot_done}), 32'd0);
    check("resetState", 32'(dbg0), 32'(IDLE));

    // No requests: nothing is ever granted.
    drive(1'b1, 4'b0000, 4'b1111);
    repeat (10) tick("noReq");

    // All channels requesting: 0,1,2,3,0 each held 4 cycles.
    drive(1'b1, 4'b1111, 4'b1010);
    for (int k = 0; k < 20; k++) begin
      tick("allReq");
      check("rrSel", 32'(bus0.sel), 32'((k / 4) % 4));
      check("rrData", 32'(bus0.data), 32'(((k / 4) % 4) & 1));
      check("rrDone", 32'(bus0.slot_done), 32'((k % 4) == 3));
    end

    // Single requester re-granted back-to-back.
    drive(1'b1, 4'b0100, 4'b0100);
    repeat (12) tick("single");
    check("singleSel", 32'(bus0.sel), 32'd2);

    // Early abort: channel 1 withdraws in its second slot cycle.
    drive(1'b0, 4'b0000, 4'b0000);
    repeat (6) tick("drain");
    drive(1'b1, 4'b0010, 4'b1111);
    tick("abortGrant");
    check("abortFirst", 32'(bus0.sel), 32'd1);
    tick("abortCyc2");
    drive(1'b1, 4'b1000, 4'b1111);
    tick("abortNext");
    check("abortSel", 32'(bus0.sel), 32'd3);
    check("abortValid", 32'(bus0.valid), 32'd1);

    // en dropped mid-slot: the slot still completes.
    drive(1'b0, 4'b0000, 4'b0000);
    repeat (6) tick("drain2");
    drive(1'b1, 4'b1111, 4'b0001);
    tick("enCyc1");
    tick("enCyc2");
    drive(1'b0, 4'b1111, 4'b0001);
    tick("enCyc3");
    tick("enCyc4");
    check("enDone", 32'(bus0.slot_done), 32'd1);
    tick("enIdle");
    check("enIdleValid", 32'(bus0.valid), 32'd0);
    check("enIdleData", 32'(bus0.data), 32'd0);

    // Randomized traffic with occasional request changes (aborts included).
    for (int n = 0; n < 400; n++) begin
      logic       e;
      logic [3:0] r;
      e = ($urandom_range(0, 9) != 0);
      r = bus0.req;
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      drive(e, r, 4'($urandom_range(0, 15)));
      tick("random");
    end

    // Asynchronous reset mid-slot, then channel 0 is favoured.
    drive(1'b1, 4'b1111, 4'b1111);
    tick("preRst1");
    tick("preRst2");
    #2;
    rst_n = 1'b0;
    #1;
    check("rstValid", 32'(bus0.valid), 32'd0);
    check("rstData", 32'(bus0.data), 32'd0);
    check("rstSel", 32'(bus0.sel), 32'd0);
    check("rstDone", 32'(bus0.slot_done), 32'd0);
    modelReset();
    drive(1'b1, 4'b1001, 4'b1111);
    @(negedge clk);
    rst_n = 1'b1;
    tick("postRst");
    check("postRstSel", 32'(bus0.sel), 32'd0);
    check("postRstData", 32'(bus0.data), 32'd1);
    repeat (8) tick("postRstRun");

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

// File: doc/tdm_mux_scanner.md
# tdm_mux_scanner

Time-division transmitter that drives the shared `data`/`sel` pair consumed by the 1-to-4 enable demultiplexer. It grants four requesting channels in rotating priority. Each grant holds for a programmable dwell period, and during that period the scanner forwards the granted channel's bit on `data` with the matching `sel` code. It sits between the four channel sources (buttons or switch logic) and the demultiplexer, so the demultiplexer only ever sees one selected channel at a time.

## Interface
- `DWELL`, 4: cycles per grant slot; legal range 1..65535.
- `CNT_W`, max(1, clog2(DWELL)): dwell counter width; derived, not overridden.

- `clk`  in  1  single system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset; assertion clears all state immediately; deassertion is synchronous to `clk` at the system level.
- `en`  in  1  scan enable; when low, no new slot starts.
- `req`  in  4  per-channel request; bit i means channel i wants a slot.
- `ch_data`  in  4  per-channel data bit; bit i is forwarded while channel i is granted.
- `data`  out  1  registered forwarded bit; 0 whenever `valid` = 0.
- `sel`  out  2  registered granted channel index.
- `valid`  out  1  high while a slot is active.
- `slot_done`  out  1  one-cycle pulse in the final cycle of a slot that completed its full dwell.

## Operation
- The FSM has two states: IDLE and GRANT.
- Reset values: state = IDLE, `sel` = 0, `data` = 0, `valid` = 0, `slot_done` = 0, last-granted pointer = 3 (channel 0 has first priority), dwell counter = 0.
- Arbitration is round-robin. The search starts at (last + 1) mod 4 and takes the first index with `req` set. When the grant is taken, the last-granted pointer is updated to the granted index.
- IDLE -> GRANT: when `en` = 1 and `req` != 0, then on the next edge:
  - `sel` = granted index
  - `valid` = 1
  - counter = DWELL-1
- In GRANT, each cycle:
  - `data` <= `ch_data[sel]`
  - the counter decrements while it is nonzero.
- Normal end of slot: the counter reaches 0.
  - `slot_done` = 1 in that cycle.
  - At the next edge, if `en` = 1 and `req` != 0, the next grant starts back-to-back, with no idle cycle.
  - Otherwise the FSM returns to IDLE with `valid` = 0 and `data` = 0.
- Early abort: the granted channel drops `req` mid-slot.
  - The slot ends at the next edge with no `slot_done`.
  - Arbitration runs in the same cycle as normal slot end.
- `en` deasserted mid-slot: the current slot runs to completion, including `slot_done`, then the FSM goes to IDLE.
- With a single requester, that channel is re-granted back-to-back indefinitely.
- With DWELL = 1, every slot lasts exactly one cycle and `slot_done` is high in that same cycle.
- `sel` holds its last value in IDLE. `data` is forced to 0 in IDLE so that all demultiplexer enables stay low.

## Timing
- Grant latency: `req` or `en` sampled high at edge N gives `valid`/`sel` at N+1.
- Data latency: `data` at cycle k equals `ch_data[sel]` sampled at edge k, which is one cycle of latency through the register.
- On the first cycle of a slot, `data` = `ch_data[new sel]` sampled at the granting edge.
- Slot length: exactly DWELL cycles of `valid` = 1 per completed grant.
- Back-to-back grants: `valid` stays high continuously, and `sel` changes on the edge after `slot_done`.
- `req` changes on non-granted channels have no effect until the next arbitration point.
- Reset mid-slot: all outputs drop to their reset values asynchronously. The first post-reset grant favours channel 0.

## Structure
- Shared package `tdm_pkg` holds:
  - `NUM_CH` = 4
  - `SEL_W` = 2
  - the state enum {IDLE, GRANT}.
  The demultiplexer side imports `SEL_W` from this package as well.
- One sub-module, `rr_arbiter_4`: a combinational rotating-priority picker.
  - Inputs: `req[3:0]`, `last[1:0]`.
  - Outputs: `gnt_idx[1:0]`, `any`.
- The top level holds the FSM, the dwell counter, the pointer register and the output registers.

## Test plan
- Reset, then `req` = 4'b0000, `en` = 1 for 10 cycles -> `valid` = 0, `data` = 0, `sel` = 0 throughout.
- DWELL = 4, `req` = 4'b1111, `ch_data` = 4'b1010, `en` = 1 -> expected response:
  - `sel` sequence 0,1,2,3,0, each held for 4 cycles with `valid` continuously high
  - `data` = 0,1,0,1
  - `slot_done` pulses every 4th cycle.
- `req` = 4'b0100 only -> `sel` = 2 is re-granted back-to-back, with `slot_done` every 4 cycles.
- Grant channel 1, then drop `req[1]` in the 2nd slot cycle while `req[3]` = 1 -> no `slot_done`, and `sel` = 3 on the following edge.
- Drop `en` in the 2nd cycle of a slot -> the slot completes all 4 cycles with `slot_done`, then `valid` = 0 and `data` = 0.
- Assert `rst_n` = 0 mid-slot -> `valid` and `data` go to 0 immediately. After release with `req` = 4'b1001, the first grant is `sel` = 0.
